// File: rtl/gpsw_pkg.sv
// Shared defaults and types for the GP switch debouncer.
package gpsw_pkg;

    localparam int unsigned NUM_SW_DEF       = 16;
    localparam int unsigned TICK_DIV_DEF     = 50000;
    localparam int unsigned STABLE_TICKS_DEF = 10;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_PEND = 1'b1
    } chan_st_e;

    typedef struct packed {
        logic [NUM_SW_DEF-1:0] db;
        logic [NUM_SW_DEF-1:0] rise;
        logic [NUM_SW_DEF-1:0] fall;
        logic                  irq;
    } type_gpsw2gpio_s;

endpackage

// File: rtl/gpsw_debounce_if.sv
// Switch-side bundle between the debouncer and its consumer.
interface gpsw_debounce_if
    import gpsw_pkg::*;
#(
    parameter int unsigned NUM_SW = NUM_SW_DEF
);

    logic [NUM_SW-1:0] sw_raw_i;
    logic              en_i;
    logic              irq_clr_i;
    logic [NUM_SW-1:0] sw_db_o;
    logic [NUM_SW-1:0] sw_rise_o;
    logic [NUM_SW-1:0] sw_fall_o;
    logic              sw_irq_o;

    modport master (
        output sw_raw_i, en_i, irq_clr_i,
        input  sw_db_o, sw_rise_o, sw_fall_o, sw_irq_o
    );

    modport slave (
        input  sw_raw_i, en_i, irq_clr_i,
        output sw_db_o, sw_rise_o, sw_fall_o, sw_irq_o
    );

endinterface

// File: rtl/gpsw_chan.sv
// One switch channel: 2-flop synchronizer, tick-qualified debounce and edge pulses.
module gpsw_chan
    import gpsw_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw_i,
    input  logic en_i,
    input  logic tick_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          sync1_q;
    logic          sync_q;
    logic [CW-1:0] cnt_q;
    logic          db_q;
    logic          rise_q;
    logic          fall_q;
    chan_st_e      st_c;

    // Channel is pending whenever the synchronized level disagrees with the accepted one.
    assign st_c = (sync_q != db_q) ? CH_PEND : CH_IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sw_raw_i;
            sync_q  <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            if (!en_i || st_c == CH_IDLE) begin
                cnt_q <= '0;
            end else if (tick_i) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_q  <= '0;
                    db_q   <= sync_q;
                    rise_q <= sync_q;
                    fall_q <= ~sync_q;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/gpsw_debounce.sv
// Debouncer top: shared sample prescaler, sticky change interrupt, NUM_SW channels.
module gpsw_debounce
    import gpsw_pkg::*;
#(
    parameter int unsigned NUM_SW       = NUM_SW_DEF,
    parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic           clk,
    input  logic           rst,
    gpsw_debounce_if.slave bus
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]     presc_q;
    logic              tick_c;
    logic              irq_q;
    logic [NUM_SW-1:0] sw_db;
    logic [NUM_SW-1:0] sw_rise;
    logic [NUM_SW-1:0] sw_fall;

    assign tick_c = bus.en_i && (presc_q == PRESC_LAST);

    // Held at zero while disabled so re-enable always starts a full sample period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else if (!bus.en_i || tick_c) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Set has priority over clear so a coincident clear never loses an event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else if ((|sw_rise) || (|sw_fall)) begin
            irq_q <= 1'b1;
        end else if (bus.irq_clr_i) begin
            irq_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_chan
        gpsw_chan #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .sw_raw_i (bus.sw_raw_i[i]),
            .en_i     (bus.en_i),
            .tick_i   (tick_c),
            .db_o     (sw_db[i]),
            .rise_o   (sw_rise[i]),
            .fall_o   (sw_fall[i])
        );
    end

    assign bus.sw_db_o   = sw_db;
    assign bus.sw_rise_o = sw_rise;
    assign bus.sw_fall_o = sw_fall;
    assign bus.sw_irq_o  = irq_q;

endmodule

// File: tb/tb_gpsw_debounce.sv
// Directed bench for gpsw_debounce with TICK_DIV=4, STABLE_TICKS=3.
module tb_gpsw_debounce;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    gpsw_debounce_if #(.NUM_SW(16)) bus ();

    gpsw_debounce #(
        .NUM_SW       (16),
        .TICK_DIV     (4),
        .STABLE_TICKS (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        bus.irq_clr_i = 1'b1;
        step();
        bus.irq_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        bus.sw_raw_i  = '0;
        bus.en_i      = 1'b1;
        bus.irq_clr_i = 1'b0;
        #2;
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if (bus.sw_db_o !== 16'h0000) begin
            n_err++; $display("FAIL reset_db: got %h expected 0000", bus.sw_db_o);
        end
        n_cmp++;
        if ({bus.sw_rise_o, bus.sw_fall_o} !== 32'h0) begin
            n_err++; $display("FAIL reset_edges: got %h/%h expected 0/0", bus.sw_rise_o, bus.sw_fall_o);
        end
        n_cmp++;
        if (bus.sw_irq_o !== 1'b0) begin
            n_err++; $display("FAIL reset_irq: got %b expected 0", bus.sw_irq_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if ({bus.sw_db_o, bus.sw_rise_o, bus.sw_fall_o, bus.sw_irq_o} !== 49'h0) begin
            n_err++; $display("FAIL post_reset_idle: got db=%h irq=%b expected 0000/0", bus.sw_db_o, bus.sw_irq_o);
        end
    endtask

    task automatic test_glitch();
        bus.sw_raw_i = 16'h0008;
        for (int i = 0; i < 36; i++) begin
            if (i == 6) bus.sw_raw_i = 16'h0000;
            step();
            n_cmp++;
            if (bus.sw_db_o[3] !== 1'b0 || bus.sw_rise_o !== 16'h0 || bus.sw_fall_o !== 16'h0
                || bus.sw_irq_o !== 1'b0) begin
                n_err++;
                $display("FAIL glitch_c%0d: got db=%h rise=%h fall=%h irq=%b expected 0000/0000/0000/0",
                         i, bus.sw_db_o, bus.sw_rise_o, bus.sw_fall_o, bus.sw_irq_o);
            end
        end
    endtask

    task automatic test_single_rise();
        int n;
        n = 0;
        bus.sw_raw_i = 16'h0001;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.sw_db_o[0] === 1'b1) begin
                n = i;
                break;
            end
        end
        n_cmp++;
        if (n < 11 || n > 14) begin
            n_err++; $display("FAIL rise_latency: got %0d cycles expected 11..14", n);
        end
        n_cmp++;
        if (bus.sw_rise_o !== 16'h0001 || bus.sw_fall_o !== 16'h0000) begin
            n_err++; $display("FAIL rise_pulse: got rise=%h fall=%h expected 0001/0000", bus.sw_rise_o, bus.sw_fall_o);
        end
        step();
        n_cmp++;
        if (bus.sw_rise_o !== 16'h0000 || bus.sw_db_o !== 16'h0001) begin
            n_err++; $display("FAIL rise_one_cycle: got rise=%h db=%h expected 0000/0001", bus.sw_rise_o, bus.sw_db_o);
        end
        n_cmp++;
        if (bus.sw_irq_o !== 1'b1) begin
            n_err++; $display("FAIL rise_irq: got %b expected 1", bus.sw_irq_o);
        end
    endtask

    task automatic test_irq_collision();
        int n;
        n = 0;
        pulse_clr();
        n_cmp++;
        if (bus.sw_irq_o !== 1'b0) begin
            n_err++; $display("FAIL irq_clear_first: got %b expected 0", bus.sw_irq_o);
        end
        bus.sw_raw_i = 16'h0000;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.sw_db_o[0] === 1'b0) begin
                n = i;
                break;
            end
        end
        n_cmp++;
        if (n < 11 || n > 14 || bus.sw_fall_o !== 16'h0001 || bus.sw_rise_o !== 16'h0000) begin
            n_err++;
            $display("FAIL fall_pulse: got %0d cycles fall=%h rise=%h expected 11..14/0001/0000",
                     n, bus.sw_fall_o, bus.sw_rise_o);
        end
        pulse_clr();
        n_cmp++;
        if (bus.sw_irq_o !== 1'b1) begin
            n_err++; $display("FAIL irq_set_wins: got %b expected 1", bus.sw_irq_o);
        end
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (bus.sw_irq_o !== 1'b1) begin
            n_err++; $display("FAIL irq_sticky: got %b expected 1", bus.sw_irq_o);
        end
        pulse_clr();
        n_cmp++;
        if (bus.sw_irq_o !== 1'b0) begin
            n_err++; $display("FAIL irq_lone_clear: got %b expected 0", bus.sw_irq_o);
        end
    endtask

    task automatic test_all_rise();
        int n;
        n = 0;
        bus.sw_raw_i = 16'hFFFF;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.sw_db_o !== 16'h0000) begin
                n = i;
                break;
            end
        end
        n_cmp++;
        if (n < 11 || n > 14 || bus.sw_db_o !== 16'hFFFF) begin
            n_err++; $display("FAIL all_rise_db: got %0d cycles db=%h expected 11..14/ffff", n, bus.sw_db_o);
        end
        n_cmp++;
        if (bus.sw_rise_o !== 16'hFFFF) begin
            n_err++; $display("FAIL all_rise_pulse: got %h expected ffff", bus.sw_rise_o);
        end
        step();
        n_cmp++;
        if (bus.sw_rise_o !== 16'h0000) begin
            n_err++; $display("FAIL all_rise_one_cycle: got %h expected 0000", bus.sw_rise_o);
        end
        n = 0;
        bus.sw_raw_i = 16'h0000;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.sw_db_o !== 16'hFFFF) begin
                n = i;
                break;
            end
        end
        n_cmp++;
        if (bus.sw_db_o !== 16'h0000 || bus.sw_fall_o !== 16'hFFFF) begin
            n_err++; $display("FAIL all_fall: got db=%h fall=%h expected 0000/ffff", bus.sw_db_o, bus.sw_fall_o);
        end
        step();
        pulse_clr();
    endtask

    task automatic test_enable();
        int n;
        n = 0;
        bus.en_i = 1'b0;
        step();
        // Re-enable aligns the prescaler: ticks land 4 and 8 edges later.
        bus.en_i     = 1'b1;
        bus.sw_raw_i = 16'h0020;
        for (int i = 0; i < 8; i++) step();
        bus.en_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if (bus.sw_db_o !== 16'h0000 || bus.sw_rise_o !== 16'h0000 || bus.sw_irq_o !== 1'b0) begin
                n_err++;
                $display("FAIL disabled_c%0d: got db=%h rise=%h irq=%b expected 0000/0000/0",
                         i, bus.sw_db_o, bus.sw_rise_o, bus.sw_irq_o);
            end
        end
        bus.en_i = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.sw_db_o[5] === 1'b1) begin
                n = i;
                break;
            end
        end
        n_cmp++;
        if (n < 11 || n > 14) begin
            n_err++; $display("FAIL reenable_latency: got %0d cycles expected 11..14", n);
        end
        n_cmp++;
        if (bus.sw_rise_o !== 16'h0020) begin
            n_err++; $display("FAIL reenable_pulse: got %h expected 0020", bus.sw_rise_o);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        bus.sw_raw_i = 16'h00A0;
        for (int i = 0; i < 6; i++) step();
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.sw_db_o !== 16'h0000 || bus.sw_irq_o !== 1'b0 || bus.sw_rise_o !== 16'h0000) begin
            n_err++;
            $display("FAIL async_reset: got db=%h irq=%b rise=%h expected 0000/0/0000",
                     bus.sw_db_o, bus.sw_irq_o, bus.sw_rise_o);
        end
        step();
        step();
        rst = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.sw_db_o !== 16'h0000) begin
                n = i;
                break;
            end
        end
        n_cmp++;
        if (n < 11 || n > 14 || bus.sw_db_o !== 16'h00A0) begin
            n_err++; $display("FAIL requal_db: got %0d cycles db=%h expected 11..14/00a0", n, bus.sw_db_o);
        end
        n_cmp++;
        if (bus.sw_rise_o !== 16'h00A0 || bus.sw_fall_o !== 16'h0000) begin
            n_err++; $display("FAIL requal_pulse: got rise=%h fall=%h expected 00a0/0000", bus.sw_rise_o, bus.sw_fall_o);
        end
        step();
        n_cmp++;
        if (bus.sw_rise_o !== 16'h0000 || bus.sw_irq_o !== 1'b1) begin
            n_err++; $display("FAIL requal_after: got rise=%h irq=%b expected 0000/1", bus.sw_rise_o, bus.sw_irq_o);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_glitch();
        test_single_rise();
        test_irq_collision();
        test_all_rise();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpsw_debounce.md
GPSW_DEBOUNCE -- requirements
Module: gpsw_debounce

Interface
REQ-001 Parameter NUM_SW, default 16: number of switch channels; matches the width of the gp_switch_i pins.
REQ-002 Parameter TICK_DIV, default 50000: clk cycles per sample tick; legal range 2..2^20.
REQ-003 Parameter STABLE_TICKS, default 10: consecutive mismatched ticks needed to accept a new level; legal range 1..15.
REQ-004 clk  input  1  single block clock; the only clock in this block.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sw_raw_i  input  NUM_SW  raw switch pins, asynchronous to clk.
REQ-007 en_i  input  1  filter enable, level.
REQ-008 irq_clr_i  input  1  single-cycle pulse that clears sw_irq_o.
REQ-009 sw_db_o  output  NUM_SW  debounced switch levels, registered; feeds gp_switch_i.
REQ-010 sw_rise_o  output  NUM_SW  one-cycle pulse per channel on a debounced 0->1 change.
REQ-011 sw_fall_o  output  NUM_SW  one-cycle pulse per channel on a debounced 1->0 change.
REQ-012 sw_irq_o  output  1  sticky level, set by any debounced change; feeds sw_irq.

Function
REQ-013 Each raw bit SHALL pass through a 2-flop synchronizer (sync_q); debounce logic uses only sync_q.
REQ-014 Prescaler: counts 0..TICK_DIV-1, then wraps to 0; tick is asserted for exactly one cycle, when the count equals TICK_DIV-1.
REQ-015 Per channel, state SHALL be IDLE (sync_q==sw_db_o) or PEND (sync_q!=sw_db_o), with a cnt field of width clog2(STABLE_TICKS+1).
REQ-016 In any cycle where sync_q==sw_db_o, cnt SHALL clear to 0 and the channel returns to IDLE; a glitch therefore restarts qualification.
REQ-017 In PEND with tick high, cnt SHALL increment.
REQ-018 When cnt==STABLE_TICKS-1 and tick is high in PEND, then in the next cycle: sw_db_o bit takes the sync_q value, cnt clears, and exactly one of sw_rise_o or sw_fall_o pulses for that bit.
REQ-019 Edge pulses SHALL be asserted in the same cycle as the sw_db_o change; several channels may pulse in the same cycle.
REQ-020 Latency from a stable raw change to the sw_db_o change: min 2+(STABLE_TICKS-1)*TICK_DIV+1 cycles, max 2+STABLE_TICKS*TICK_DIV cycles.
REQ-021 sw_irq_o SHALL set on the cycle after any rise or fall pulse, and clear on the cycle after irq_clr_i; when set and clear coincide, set wins.
REQ-022 With en_i low: prescaler held at 0, all cnt held at 0, sw_db_o frozen, no edge pulses; the synchronizer keeps running.
REQ-023 When en_i rises, the prescaler restarts from 0; qualification starts fresh and no stale count carries over.

Reset
REQ-024 Under rst: synchronizer flops, prescaler, cnt, sw_db_o, sw_rise_o, sw_fall_o and sw_irq_o all reset to 0, asynchronously.
REQ-025 Reset assertion mid-qualification SHALL discard pending counts; after release, switches held high are re-qualified as rise events.

Structure
REQ-026 A shared package gpsw_pkg SHALL hold the NUM_SW, TICK_DIV and STABLE_TICKS defaults and a struct type_gpsw2gpio_s {db, rise, fall, irq}.
REQ-027 One sub-module, gpsw_chan (synchronizer + per-channel state/cnt + edge pulse), SHALL be instantiated NUM_SW times.
REQ-028 The prescaler and the irq flop are shared and live in gpsw_debounce itself.

Verification (bench parameters TICK_DIV=4, STABLE_TICKS=3, en_i=1)
REQ-029 sw_raw_i[0] 0->1, held -> sw_db_o[0]=1 within 11..14 cycles; sw_rise_o[0] pulses for 1 cycle; sw_irq_o=1 on the next cycle.
REQ-030 sw_raw_i[3] high for 6 cycles, then low -> sw_db_o[3] stays 0; no pulses; sw_irq_o stays 0.
REQ-031 sw_raw_i=16'hFFFF, held -> all 16 bits rise in the same cycle; sw_rise_o=16'hFFFF for 1 cycle.
REQ-032 irq_clr_i pulsed in the same cycle as the irq set condition -> sw_irq_o remains 1; a later lone irq_clr_i -> sw_irq_o=0 on the next cycle.
REQ-033 Drop en_i after 2 ticks of PEND on bit 5, hold 20 cycles, re-raise -> a full 11..14 cycles are needed from re-enable; no pulse while disabled.
REQ-034 Assert rst mid-PEND with sw_raw_i[7]=1, then release -> outputs 0 immediately; sw_db_o[7]=1 after 11..14 cycles with one rise pulse.
